cp0_reg: RTL and testbench

Coprocessor-0 register file for the multi-cycle MIPS core. It is the responder side of the MEM stage's exception and CP0 interface:
- Takes the exception type, instruction address and delay-slot flag resolved in MEM.
- Takes CP0 writes retired from WB.
- Holds Count/Compare/Status/Cause/EPC with the architectural update rules.
- Returns Status/Cause/EPC to MEM and read data to EX.
- Raises the timer interrupt.

---
 rtl/cp0_defs.sv | 49 ++++
 rtl/cp0_reg.sv | 99 +++++++++
 tb/tb_cp0_reg.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception type codes, ExcCode values,
// the Status reset constant and the excepttype -> ExcCode decode.
package cp0_defs;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TR      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_RI  = 5'd10;
  localparam logic [4:0] EXCCODE_OV  = 5'd12;
  localparam logic [4:0] EXCCODE_TR  = 5'd13;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } exc_dec_t;

  // hit is set only for the exceptions that enter the handler; eret is handled separately.
  function automatic exc_dec_t exc_decode(input logic [31:0] excepttype);
    exc_dec_t d;
    d.hit  = 1'b1;
    d.code = EXCCODE_INT;
    unique case (excepttype)
      EXC_INT:     d.code = EXCCODE_INT;
      EXC_SYSCALL: d.code = EXCCODE_SYS;
      EXC_RI:      d.code = EXCCODE_RI;
      EXC_OV:      d.code = EXCCODE_OV;
      EXC_TR:      d.code = EXCCODE_TR;
      default:     d.hit  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare/Status/Cause/EPC, exception entry/eret
// updates from MEM, CP0 writes from WB, combinational reads for EX, timer interrupt.
module cp0_reg
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] status_nxt, cause_nxt, epc_nxt;
  exc_dec_t    dec;

  assign wr_count   = we_i && (waddr_i == CP0_REG_COUNT);
  assign wr_compare = we_i && (waddr_i == CP0_REG_COMPARE);
  assign wr_status  = we_i && (waddr_i == CP0_REG_STATUS);
  assign wr_cause   = we_i && (waddr_i == CP0_REG_CAUSE);
  assign wr_epc     = we_i && (waddr_i == CP0_REG_EPC);
  assign dec        = exc_decode(excepttype_i);

  // WB write data first, then exception fields layered on top so they win.
  always_comb begin
    status_nxt = status_o;
    cause_nxt  = cause_o;
    epc_nxt    = epc_o;
    if (wr_status) status_nxt = data_i;
    if (wr_epc)    epc_nxt    = data_i;
    if (wr_cause) begin
      cause_nxt[23:22] = data_i[23:22];
      cause_nxt[9:8]   = data_i[9:8];
    end
    cause_nxt[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
    if (dec.hit) begin
      cause_nxt[6:2] = dec.code;
      if (!status_o[1]) begin
        epc_nxt       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_nxt[31] = is_in_delayslot_i;
      end
      status_nxt[1] = 1'b1;
    end else if (excepttype_i == EXC_ERET) begin
      status_nxt[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_o     <= '0;
      compare_o   <= '0;
      status_o    <= STATUS_RESET;
      cause_o     <= '0;
      epc_o       <= '0;
      timer_int_o <= 1'b0;
    end else begin
      count_o  <= wr_count ? data_i : count_o + 32'd1;
      status_o <= status_nxt;
      cause_o  <= cause_nxt;
      epc_o    <= epc_nxt;
      // A Compare write acknowledges the timer even if a match happens this edge.
      if (wr_compare) begin
        compare_o   <= data_i;
        timer_int_o <= 1'b0;
      end else if ((compare_o != 32'd0) && (count_o == compare_o)) begin
        timer_int_o <= 1'b1;
      end
    end
  end

  always_comb begin
    unique case (raddr_i)
      CP0_REG_COUNT:   data_o = count_o;
      CP0_REG_COMPARE: data_o = compare_o;
      CP0_REG_STATUS:  data_o = status_o;
      CP0_REG_CAUSE:   data_o = cause_o;
      CP0_REG_EPC:     data_o = epc_o;
      CP0_REG_PRID:    data_o = PRID_VAL;
      CP0_REG_CONFIG:  data_o = CONFIG_VAL;
      default:         data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus a randomized run
// against a field-level behavioural model of the CP0 registers.
module tb_cp0_reg;

  localparam logic [31:0] PRID   = 32'h004c_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  // Model state kept as architectural fields rather than packed registers.
  logic [31:0] m_count, m_compare, m_status, m_epc;
  logic        m_timer, m_bd, m_iv, m_wp;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_iphw;
  logic [4:0]  m_exc;

  always #5 clk = ~clk;

  cp0_reg #(.PRID_VAL(PRID), .CONFIG_VAL(CONFIG)) dut (
    .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .data_o(data_o), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  function automatic logic [31:0] m_cause();
    return {m_bd, 7'b0, m_iv, m_wp, 6'b0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONFIG;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; int_i = 6'd0;
    excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  // Advance one clock: predict next state from current inputs, then step the DUT.
  task automatic tick();
    logic [31:0] n_count, n_compare, n_status, n_epc;
    logic        n_timer, n_bd, n_iv, n_wp, hit;
    logic [1:0]  n_ipsw;
    logic [5:0]  n_iphw;
    logic [4:0]  n_exc, code;
    if (!resetn) begin
      n_count = 0; n_compare = 0; n_status = 32'h1000_0000; n_epc = 0; n_timer = 0;
      n_bd = 0; n_iv = 0; n_wp = 0; n_ipsw = 0; n_iphw = 0; n_exc = 0;
    end else begin
      n_count = (we_i && waddr_i == 5'd9) ? data_i : m_count + 32'd1;
      n_compare = m_compare; n_timer = m_timer;
      if (we_i && waddr_i == 5'd11) begin
        n_compare = data_i; n_timer = 1'b0;
      end else if (m_compare != 0 && m_count == m_compare) begin
        n_timer = 1'b1;
      end
      n_status = (we_i && waddr_i == 5'd12) ? data_i : m_status;
      n_epc    = (we_i && waddr_i == 5'd14) ? data_i : m_epc;
      n_bd = m_bd; n_iv = m_iv; n_wp = m_wp; n_ipsw = m_ipsw; n_exc = m_exc;
      if (we_i && waddr_i == 5'd13) begin
        n_iv = data_i[23]; n_wp = data_i[22]; n_ipsw = data_i[9:8];
      end
      n_iphw = {int_i[5] | m_timer, int_i[4:0]};
      hit = 1'b1; code = 5'd0;
      case (excepttype_i)
        32'h1:   code = 5'd0;
        32'h8:   code = 5'd8;
        32'ha:   code = 5'd10;
        32'hc:   code = 5'd12;
        32'hd:   code = 5'd13;
        default: hit = 1'b0;
      endcase
      if (hit) begin
        n_exc = code;
        if (m_status[1] == 1'b0) begin
          n_epc = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
          n_bd  = is_in_delayslot_i;
        end
        n_status[1] = 1'b1;
      end else if (excepttype_i == 32'he) begin
        n_status[1] = 1'b0;
      end
    end
    @(posedge clk);
    m_count = n_count; m_compare = n_compare; m_status = n_status; m_epc = n_epc;
    m_timer = n_timer; m_bd = n_bd; m_iv = n_iv; m_wp = n_wp; m_ipsw = n_ipsw;
    m_iphw = n_iphw; m_exc = n_exc;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h1234_5678;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h40;
    tick();
    tick();
    idle_inputs();
    total++;
    if (status_o !== 32'h1000_0000) begin
      bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h1000_0000);
    end
    total++;
    if ({count_o, compare_o, cause_o, epc_o} !== 128'd0 || timer_int_o !== 1'b0) begin
      bad++; $display("FAIL reset_zero got=%h %h %h %h %b exp=0", count_o, compare_o, cause_o, epc_o, timer_int_o);
    end
    resetn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (count_o !== 32'(i)) begin
        bad++; $display("FAIL count_after_release got=%0d exp=%0d", count_o, i);
      end
    end
  endtask

  task automatic test_count_wrap();
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFF_FFFE;
    tick();
    idle_inputs();
    tick();
    total++;
    if (count_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL count_load got=%h exp=%h", count_o, 32'hFFFF_FFFF);
    end
    tick();
    total++;
    if (count_o !== 32'd0) begin
      bad++; $display("FAIL count_wrap got=%h exp=0", count_o);
    end
  endtask

  task automatic test_timer();
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd20;
    tick();
    waddr_i = 5'd9; data_i = 32'd15;
    tick();
    idle_inputs();
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (timer_int_o !== (i == 6)) begin
        bad++; $display("FAIL timer_edge%0d got=%b exp=%b", i, timer_int_o, (i == 6));
      end
    end
    total++;
    if (cause_o[15] !== 1'b0) begin
      bad++; $display("FAIL cause_ip7_early got=%b exp=0", cause_o[15]);
    end
    tick();
    total++;
    if (cause_o[15] !== 1'b1 || timer_int_o !== 1'b1) begin
      bad++; $display("FAIL timer_sticky_ip7 got=%b/%b exp=1/1", cause_o[15], timer_int_o);
    end
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd0;
    tick();
    idle_inputs();
    total++;
    if (timer_int_o !== 1'b0) begin
      bad++; $display("FAIL timer_clear got=%b exp=0", timer_int_o);
    end
    tick();
    total++;
    if (cause_o[15] !== 1'b0) begin
      bad++; $display("FAIL cause_ip7_clear got=%b exp=0", cause_o[15]);
    end
  endtask

  task automatic test_syscall_ds();
    excepttype_i = 32'h8; current_inst_addr_i = 32'h0000_0104; is_in_delayslot_i = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (epc_o !== 32'h0000_0100 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd8 || status_o[1] !== 1'b1) begin
      bad++; $display("FAIL syscall_ds epc=%h bd=%b exc=%0d exl=%b exp=00000100 1 8 1",
                      epc_o, cause_o[31], cause_o[6:2], status_o[1]);
    end
  endtask

  task automatic test_nested();
    excepttype_i = 32'hc; current_inst_addr_i = 32'h0000_0200;
    tick();
    idle_inputs();
    total++;
    if (epc_o !== 32'h0000_0100 || cause_o[6:2] !== 5'd12 || cause_o[31] !== 1'b1) begin
      bad++; $display("FAIL nested epc=%h exc=%0d bd=%b exp=00000100 12 1", epc_o, cause_o[6:2], cause_o[31]);
    end
  endtask

  task automatic test_eret();
    excepttype_i = 32'he;
    tick();
    idle_inputs();
    total++;
    if (status_o[1] !== 1'b0 || epc_o !== 32'h0000_0100 || cause_o[6:2] !== 5'd12) begin
      bad++; $display("FAIL eret exl=%b epc=%h exc=%0d exp=0 00000100 12", status_o[1], epc_o, cause_o[6:2]);
    end
    // Status write together with a syscall: written value, EXL forced high.
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_FF00;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h0000_0300;
    tick();
    idle_inputs();
    total++;
    if (status_o !== 32'h0000_FF02 || epc_o !== 32'h0000_0300 || cause_o[31] !== 1'b0) begin
      bad++; $display("FAIL status_wr_exc st=%h epc=%h bd=%b exp=0000ff02 00000300 0", status_o, epc_o, cause_o[31]);
    end
  endtask

  task automatic test_cause_mask();
    do_reset();
    we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    total++;
    if (cause_o !== 32'h00C0_0300) begin
      bad++; $display("FAIL cause_mask got=%h exp=%h", cause_o, 32'h00C0_0300);
    end
  endtask

  task automatic test_reads();
    raddr_i = 5'd15; #1;
    total++;
    if (data_o !== PRID) begin
      bad++; $display("FAIL read_prid got=%h exp=%h", data_o, PRID);
    end
    raddr_i = 5'd7; #1;
    total++;
    if (data_o !== 32'd0) begin
      bad++; $display("FAIL read_unused got=%h exp=0", data_o);
    end
    raddr_i = 5'd16; #1;
    total++;
    if (data_o !== CONFIG) begin
      bad++; $display("FAIL read_config got=%h exp=%h", data_o, CONFIG);
    end
    raddr_i = 5'd13; #1;
    total++;
    if (data_o !== 32'h00C0_0300) begin
      bad++; $display("FAIL read_cause got=%h exp=%h", data_o, 32'h00C0_0300);
    end
  endtask

  task automatic test_random();
    logic [4:0]  regs [6]  = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    logic [31:0] codes [8] = '{32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h5};
    for (int n = 0; n < 400; n++) begin
      resetn              = ($urandom_range(0, 49) != 0);
      we_i                = $urandom_range(0, 1);
      waddr_i             = regs[$urandom_range(0, 5)];
      data_i              = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1) data_i = m_count + $urandom_range(0, 6);
      int_i               = 6'($urandom);
      excepttype_i        = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(1, 7)] : 32'd0;
      current_inst_addr_i = $urandom;
      is_in_delayslot_i   = $urandom_range(0, 1);
      raddr_i             = 5'($urandom_range(0, 20));
      tick();
      total++;
      if (count_o !== m_count || compare_o !== m_compare || timer_int_o !== m_timer) begin
        bad++; $display("FAIL rnd%0d timer got=%h %h %b exp=%h %h %b", n, count_o, compare_o, timer_int_o,
                        m_count, m_compare, m_timer);
      end
      total++;
      if (status_o !== m_status || cause_o !== m_cause() || epc_o !== m_epc) begin
        bad++; $display("FAIL rnd%0d exc got=%h %h %h exp=%h %h %h", n, status_o, cause_o, epc_o,
                        m_status, m_cause(), m_epc);
      end
      total++;
      if (data_o !== m_read(raddr_i)) begin
        bad++; $display("FAIL rnd%0d read r%0d got=%h exp=%h", n, raddr_i, data_o, m_read(raddr_i));
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    raddr_i = 5'd0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_count_wrap();
    test_timer();
    test_syscall_ds();
    test_nested();
    test_eret();
    test_cause_mask();
    test_reads();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
